// File: rtl/ps2_rx_sequencer.sv
// ps2_rx_sequencer
//
// Purpose:
//   Receives PS/2 keyboard frames in the system clock domain. The raw PS/2 pins are
//   synchronized and oversampled, and falling edges of the PS/2 clock drive a small FSM.
//   The FSM frames each byte as start / 8 data bits (LSB first) / odd parity / stop.
//   Good bytes are queued in a FIFO that the consumer drains with a valid/pop handshake.
//   A watchdog aborts frames that stall, and parity, framing and overflow problems are
//   reported as single-cycle pulses.
//
// Optional feature (macro PS2_BREAK_DECODE_EN):
//   When the macro is defined, the F0 (break) and E0 (extended) prefix bytes are absorbed.
//   They are returned as the brk/ext flags of the next real byte, and the FIFO is 10 bits wide.
//   When it is undefined, every good byte is queued raw and brk/ext are tied to 0.
//
// Parameters:
//   FIFO_DEPTH      scan-code FIFO entries (power of 2, >= 2)
//   TIMEOUT_CYCLES  CLK cycles without a PS/2 clock fall before an open frame is aborted
//   SYNC_STAGES     synchronizer depth for ps2_clk / ps2_data (>= 2)
//
// Ports:
//   CLK         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   ps2_clk     in   raw PS/2 clock pin
//   ps2_data    in   raw PS/2 data pin
//   rd_en       in   pop request from the consumer
//   code        out  FIFO head byte (holds its last value while empty)
//   code_valid  out  FIFO not empty
//   brk         out  head byte was preceded by F0 (decode build only)
//   ext         out  head byte was preceded by E0 (decode build only)
//   parity_err  out  1-cycle pulse, odd-parity check failed
//   frame_err   out  1-cycle pulse, stop bit was 0 or watchdog expired mid-frame
//   overflow    out  1-cycle pulse, good byte dropped because the FIFO was full

module ps2_rx_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       brk,
  output logic       ext,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PS2_BREAK_DECODE_EN
  localparam int EW = 10;
`else
  localparam int EW = 8;
`endif

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   bit_in;

  state_t        state;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [TW-1:0] wd_cnt;
  logic          push_req;
  logic [EW-1:0] push_data;
`ifdef PS2_BREAK_DECODE_EN
  logic          brk_pend;
  logic          ext_pend;
`endif

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   wr_next;
  logic [AW:0]   rd_next;
  logic          empty;
  logic          full;
  logic          pop;
  logic          do_push;
  logic [EW-1:0] head_entry;

  // Synchronizers are preset to 1 so that leaving reset never looks like a clock fall.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign bit_in = data_sync[SYNC_STAGES-1];

  // Frame FSM. It advances only on a PS/2 clock fall. The exception is the watchdog,
  // which aborts an open frame once TIMEOUT_CYCLES pass with no fall.
  // A completed good byte is handed to the FIFO through push_req on the following cycle.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      par_ok     <= 1'b0;
      wd_cnt     <= '0;
      push_req   <= 1'b0;
      push_data  <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_BREAK_DECODE_EN
      brk_pend   <= 1'b0;
      ext_pend   <= 1'b0;
`endif
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      push_req   <= 1'b0;

      if (state == IDLE || fall) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + TW'(1);
      end

      if (state != IDLE && !fall && wd_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state     <= IDLE;
        frame_err <= 1'b1;
`ifdef PS2_BREAK_DECODE_EN
        brk_pend  <= 1'b0;
        ext_pend  <= 1'b0;
`endif
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!bit_in) begin
              state  <= DATA;
              bitcnt <= '0;
            end
          end
          DATA: begin
            shreg  <= {bit_in, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par_ok <= ^{shreg, bit_in};
            state  <= STOP;
          end
          STOP: begin
            if (!par_ok) begin
              parity_err <= 1'b1;
            end
            if (!bit_in) begin
              frame_err <= 1'b1;
            end
            if (par_ok && bit_in) begin
`ifdef PS2_BREAK_DECODE_EN
              if (shreg == 8'hF0) begin
                brk_pend <= 1'b1;
              end else if (shreg == 8'hE0) begin
                ext_pend <= 1'b1;
              end else begin
                push_req  <= 1'b1;
                push_data <= {ext_pend, brk_pend, shreg};
                brk_pend  <= 1'b0;
                ext_pend  <= 1'b0;
              end
`else
              push_req  <= 1'b1;
              push_data <= shreg;
`endif
            end else begin
`ifdef PS2_BREAK_DECODE_EN
              brk_pend <= 1'b0;
              ext_pend <= 1'b0;
`endif
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // The pointers carry an extra wrap bit. Equal pointers mean empty.
  // Pointers that differ only in the wrap bit mean full.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = rd_en && !empty;
  assign do_push = push_req && (!full || pop);
  assign wr_next = wr_ptr + (AW + 1)'(do_push);
  assign rd_next = rd_ptr + (AW + 1)'(pop);

  // A byte written this cycle into the slot that becomes the head is forwarded directly.
  // That slot has not yet been written in mem.
  assign head_entry = (do_push && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) ? push_data
                                                                       : mem[rd_next[AW-1:0]];

  // Storage array. It needs no reset because entries are only read behind the write pointer.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // The pointers and the registered head outputs are updated together.
  // As a result, code_valid always reflects a non-empty FIFO, and code shows the entry that
  // is current after any pop/push on that edge.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      overflow   <= 1'b0;
`ifdef PS2_BREAK_DECODE_EN
      brk        <= 1'b0;
      ext        <= 1'b0;
`endif
    end else begin
      wr_ptr     <= wr_next;
      rd_ptr     <= rd_next;
      overflow   <= push_req && full && !pop;
      code_valid <= (wr_next != rd_next);
      if (wr_next != rd_next) begin
        code <= head_entry[7:0];
`ifdef PS2_BREAK_DECODE_EN
        brk  <= head_entry[8];
        ext  <= head_entry[9];
`endif
      end
    end
  end

`ifndef PS2_BREAK_DECODE_EN
  assign brk = 1'b0;
  assign ext = 1'b0;
`endif

endmodule
